// File: rtl/uart_tx_if.sv
// Parallel-side request and serial-side status bundle for the UART transmitter.
// The master modport faces the producer; the slave modport faces the transmit engine.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  Busy;
   logic                  TX_READY;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  TX_OUT, Busy, TX_READY
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output TX_OUT, Busy, TX_READY
   );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmit engine: start, DATA_WIDTH bits LSB first, optional parity, one stop; CLK is the bit clock.
// Define UART_TX_HOLD_REG_EN to add a one-entry hold register for gapless back-to-back frames.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic    CLK,
   input  logic    RST,
   uart_tx_if.slave tx
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_out_q, tx_out_d;
   logic                  busy_q, busy_d;
   logic                  tx_ready;
   logic                  accept;

`ifdef UART_TX_HOLD_REG_EN
   logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
   logic                  hold_par_en_q, hold_par_en_d;
   logic                  hold_par_typ_q, hold_par_typ_d;
   logic                  hold_full_q, hold_full_d;

   assign tx_ready = ~hold_full_q;
`else
   assign tx_ready = ~busy_q;
`endif

   assign accept      = tx.Data_Valid & tx_ready;
   assign tx.TX_OUT   = tx_out_q;
   assign tx.Busy     = busy_q;
   assign tx.TX_READY = tx_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
`ifdef UART_TX_HOLD_REG_EN
      hold_dat_d     = hold_dat_q;
      hold_par_en_d  = hold_par_en_q;
      hold_par_typ_d = hold_par_typ_q;
      hold_full_d    = hold_full_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               data_d    = tx.P_DATA;
               par_en_d  = tx.PAR_EN;
               par_typ_d = tx.PAR_TYP;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: state_d = STOP;
         STOP: begin
            state_d = IDLE;
`ifdef UART_TX_HOLD_REG_EN
            if (hold_full_q) begin
               state_d     = START;
               data_d      = hold_dat_q;
               par_en_d    = hold_par_en_q;
               par_typ_d   = hold_par_typ_q;
               hold_full_d = 1'b0;
            end else if (accept) begin
               state_d   = START;
               data_d    = tx.P_DATA;
               par_en_d  = tx.PAR_EN;
               par_typ_d = tx.PAR_TYP;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

`ifdef UART_TX_HOLD_REG_EN
      // Mid-frame requests park in the hold register; IDLE/STOP accepts start directly.
      if (accept && state_q != IDLE && state_q != STOP) begin
         hold_dat_d     = tx.P_DATA;
         hold_par_en_d  = tx.PAR_EN;
         hold_par_typ_d = tx.PAR_TYP;
         hold_full_d    = 1'b1;
      end
`endif

      // Outputs are decoded from the next state so the line changes on the same edge.
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = data_d[cnt_d];
         PARITY:  tx_out_d = par_typ_d ? ~^data_d : ^data_d;
         default: tx_out_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
      end
   end

`ifdef UART_TX_HOLD_REG_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hold_dat_q     <= '0;
         hold_par_en_q  <= 1'b0;
         hold_par_typ_q <= 1'b0;
         hold_full_q    <= 1'b0;
      end else begin
         hold_dat_q     <= hold_dat_d;
         hold_par_en_q  <= hold_par_en_d;
         hold_par_typ_q <= hold_par_typ_d;
         hold_full_q    <= hold_full_d;
      end
   end
`endif
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a bit-queue line model checked every cycle, plus literal frame checks.
// Handles both builds (with and without UART_TX_HOLD_REG_EN).
module tb_uart_tx_core;
   logic CLK = 1'b0;
   logic RST;

   uart_tx_if #(.DATA_WIDTH(8)) tif ();

   uart_tx_core #(.DATA_WIDTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .tx  (tif)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   // Model: cur holds the line bits still to be shown, held holds a parked frame.
   bit cur[$];
   bit held[$];
   bit fr[$];
   bit rdy_m;
   bit acc_m;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cur.delete();
         held.delete();
      end else begin
`ifdef UART_TX_HOLD_REG_EN
         rdy_m = (held.size() == 0);
`else
         rdy_m = (cur.size() == 0);
`endif
         acc_m = tif.Data_Valid && rdy_m;
         fr.delete();
         if (acc_m) begin
            fr.push_back(1'b0);
            for (int i = 0; i < 8; i++) fr.push_back(tif.P_DATA[i]);
            if (tif.PAR_EN) fr.push_back(tif.PAR_TYP ? ~^tif.P_DATA : ^tif.P_DATA);
            fr.push_back(1'b1);
         end
         if (cur.size() > 0) void'(cur.pop_front());
         if (cur.size() == 0 && held.size() > 0) begin
            cur = held;
            held.delete();
         end
         if (acc_m) begin
            if (cur.size() == 0) cur = fr;
            else held = fr;
         end
      end
   end

   function automatic logic exp_tx();
      return (cur.size() > 0) ? cur[0] : 1'b1;
   endfunction

   function automatic logic exp_rdy();
`ifdef UART_TX_HOLD_REG_EN
      return (held.size() == 0);
`else
      return (cur.size() == 0);
`endif
   endfunction

   logic [31:0] cap;
   int          ci;
   int          busy_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         cap[ci] = tif.TX_OUT;
         busy_cnt += int'(tif.Busy);
         ci++;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic pt);
      int w;
      w = 0;
      while (!tif.TX_READY && w < 50) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 50) begin
         tests++;
         fails++;
         $display("FAIL send_ready_timeout: TX_READY stayed 0, expected 1");
      end
      tif.P_DATA     = d;
      tif.PAR_EN     = pe;
      tif.PAR_TYP    = pt;
      tif.Data_Valid = 1'b1;
      @(posedge CLK);
      #2;
      tif.Data_Valid = 1'b0;
      cap      = '0;
      ci       = 0;
      busy_cnt = 0;
   endtask

   initial begin
      RST            = 1'b0;
      tif.P_DATA     = '0;
      tif.Data_Valid = 1'b0;
      tif.PAR_EN     = 1'b0;
      tif.PAR_TYP    = 1'b0;
      fork
         forever begin
            @(negedge CLK);
            check("cyc_tx_out", tif.TX_OUT, exp_tx());
            check("cyc_busy", tif.Busy, (cur.size() > 0));
            check("cyc_tx_ready", tif.TX_READY, exp_rdy());
         end
         begin
            #12;
            check("rst_tx_out", tif.TX_OUT, 1);
            check("rst_busy", tif.Busy, 0);
            check("rst_tx_ready", tif.TX_READY, 1);
            RST = 1'b1;
            capture(3);
            check("idle_line", cap[2:0], 3'b111);

            send(8'hA5, 1'b0, 1'b0);
            capture(12);
            check("a5_np_bits", cap[11:0], 12'b1111_0100_1010);
            check("a5_np_busy", busy_cnt, 10);

            send(8'hA5, 1'b1, 1'b0);
            capture(12);
            check("a5_even_bits", cap[11:0], 12'b1101_0100_1010);
            check("a5_even_par", cap[9], 0);
            check("a5_even_busy", busy_cnt, 11);

            send(8'hA5, 1'b1, 1'b1);
            capture(12);
            check("a5_odd_par", cap[9], 1);
            check("a5_odd_busy", busy_cnt, 11);

            send(8'h07, 1'b1, 1'b0);
            capture(3);
            tif.P_DATA  = 8'hFF;
            tif.PAR_TYP = 1'b1;
            tif.PAR_EN  = 1'b0;
            capture(9);
            check("07_bits", cap[11:0], 12'b1110_0000_1110);
            check("07_busy", busy_cnt, 11);

            send(8'h3C, 1'b0, 1'b0);
            capture(5);
            tif.P_DATA     = 8'h81;
            tif.Data_Valid = 1'b1;
            capture(1);
            tif.Data_Valid = 1'b0;
            capture(18);
            check("3c_bits", cap[9:0], 10'b10_0111_1000);
`ifdef UART_TX_HOLD_REG_EN
            check("81_bits", cap[19:10], 10'b11_0000_0010);
            check("81_tail", cap[23:20], 4'hF);
            check("3c_81_busy", busy_cnt, 20);
`else
            check("81_ignored", cap[23:10], 14'h3FFF);
            check("3c_busy", busy_cnt, 10);
`endif

            send(8'hFF, 1'b0, 1'b0);
            capture(6);
            check("ff_head", cap[5:0], 6'b111110);
            #1;
            RST = 1'b0;
            #1;
            check("abort_tx_out", tif.TX_OUT, 1);
            check("abort_busy", tif.Busy, 0);
            check("abort_tx_ready", tif.TX_READY, 1);
            @(posedge CLK);
            @(posedge CLK);
            #2;
            RST = 1'b1;
            capture(2);
            send(8'h55, 1'b0, 1'b0);
            capture(12);
            check("55_bits", cap[11:0], 12'b1110_1010_1010);
            check("55_busy", busy_cnt, 10);
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
